divider_sd: RTL and testbench
=============================

Name: divider_sd

Overview:
- Parametrised iterative divider for the MIPS execute stage. Serves both DIV (signed) and DIVU (unsigned) through one datapath.
- Uses non-restoring radix-2 iteration on operand magnitudes, then a registered sign/remainder fix-up cycle.
- Driven by the HI/LO control with a start/busy/done handshake.
- Results are held stable until the next start.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be at least 4. The iteration counter width is derived internally as clog2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the falling edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  load operands and begin a division; sampled on each falling edge
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  input  WIDTH  dividend; sampled with start
- divisor  input  WIDTH  divisor; sampled with start
- q  output  WIDTH  quotient (registered)
- r  output  WIDTH  remainder (registered)
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when q/r become valid

Behaviour:
- Reset (async, any time, including mid-division):
  - state=IDLE; q=0, r=0, busy=0, done=0; counter=0.
  - Any in-flight operation is discarded.
- States: IDLE, ITER, FIX.
- Load (start=1 on an edge, in any state):
  - Latch is_signed and the sign bits of both operands.
  - Latch |dividend| into the shift register. Magnitude applies only when is_signed=1; otherwise the raw value is used.
  - Latch |divisor|; clear the partial remainder and the sign flag; counter=0.
  - busy=1, done=0, state=ITER.
  - start while busy aborts the current operation and restarts with the new operands. q/r keep their previous values until the new FIX edge.
- ITER (each edge, start=0):
  - One non-restoring step. Partial remainder {rem, qmsb} minus divisor if the previous sign was positive, plus divisor otherwise.
  - Arithmetic is WIDTH+1 bits; the new quotient bit is the inverse of the result sign.
  - counter increments; after the step with counter=WIDTH-1, state=FIX.
- FIX (one edge):
  - If the final remainder is negative, add back the divisor magnitude.
  - Signed: negate q if the dividend and divisor signs differ; give r the dividend's sign.
  - Register q/r; busy=0, done=1, state=IDLE.
- done is cleared on the next edge. q/r hold until the next FIX or reset.
- Latency: start edge, then WIDTH ITER edges, then 1 FIX edge. busy is high for WIDTH+1 cycles; done is asserted on edge WIDTH+1 after the start edge.
- Divide by zero (divisor==0, either mode): FIX forces q = all ones and r = original dividend. There is no trap.
- Signed overflow (most-negative / -1): q = most-negative, r = 0. This falls out of the magnitude arithmetic with no special case.
- start with busy=0 in IDLE and start=0: state unchanged; outputs held.

Optional Feature:
- Macro DIVIDER_SD_ZERO_EARLY_EN.
- Defined:
  - Extra output port div_zero (1 bit, reset 0).
  - When divisor==0 at load, skip ITER and go directly to FIX on the next edge. busy lasts 1 cycle, done is asserted one edge after start, and q/r take the divide-by-zero values.
  - div_zero is set at that FIX edge, held until the next start or reset, and cleared at load.
- Not defined:
  - No div_zero port.
  - Divide by zero takes the full WIDTH+1 latency and produces the same q/r values.

Test Plan:
- WIDTH=32, is_signed=0, 100/7 -> busy high 33 cycles; done pulse on edge 33; q=14, r=2.
- is_signed=1, -100/7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2). Also 100/-7 -> q=-14, r=2.
- is_signed=1, 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Also is_signed=0, 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- Divide by zero, 0x12345678/0 in both modes -> q=0xFFFFFFFF, r=0x12345678.
  - Without the macro: done after 33 cycles.
  - With DIVIDER_SD_ZERO_EARLY_EN: done one edge after start, div_zero=1.
- Restart and reset: start 1000/3, re-assert start with 50/5 at ITER cycle 10 -> q=10, r=0, done after 33 cycles from the second start. Assert reset mid-ITER -> busy=0, q=r=0 immediately.
- WIDTH=8 instance, unsigned 255/16 -> q=15, r=15, busy 9 cycles. Also signed -128/-1 -> q=0x80, r=0.

Source files
------------

// File: rtl/divider_sd.sv
// Iterative non-restoring radix-2 divider (DIV/DIVU) with a registered sign/remainder fix-up cycle.
// Optional: define DIVIDER_SD_ZERO_EARLY_EN for a one-cycle divide-by-zero path and a div_zero flag.
module divider_sd #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
`ifdef DIVIDER_SD_ZERO_EARLY_EN
  ,output logic            div_zero
`endif
);

  // state | meaning
  // IDLE  | results held, waiting for start
  // ITER  | one non-restoring step per edge, WIDTH steps
  // FIX   | remainder restore, sign correction, results registered
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_raw;
  logic             sgn_mode;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  assign shifted = {acc[WIDTH-1:0], quo[WIDTH-1]};
  assign step    = acc[WIDTH] ? (shifted + {1'b0, dvs}) : (shifted - {1'b0, dvs});

  // The final remainder lies in [0, dvs) after restore, so the low WIDTH bits suffice.
  assign rem_mag = acc[WIDTH] ? (acc[WIDTH-1:0] + dvs) : acc[WIDTH-1:0];

  always_comb begin
    q_fix = quo;
    r_fix = rem_mag;
    if (dvs == '0) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end else if (sgn_mode) begin
      if (dvd_neg ^ dvs_neg) q_fix = ~quo + 1'b1;
      if (dvd_neg)           r_fix = ~rem_mag + 1'b1;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dvd_raw  <= '0;
      sgn_mode <= 1'b0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      count    <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DIVIDER_SD_ZERO_EARLY_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        sgn_mode <= is_signed;
        dvd_neg  <= dividend[WIDTH-1];
        dvs_neg  <= divisor[WIDTH-1];
        dvd_raw  <= dividend;
        quo      <= dvd_mag;
        dvs      <= dvs_mag;
        acc      <= '0;
        count    <= '0;
        busy     <= 1'b1;
        state    <= ITER;
`ifdef DIVIDER_SD_ZERO_EARLY_EN
        div_zero <= 1'b0;
        if (divisor == '0) state <= FIX;
`endif
      end else begin
        case (state)
          ITER: begin
            acc   <= step;
            quo   <= {quo[WIDTH-2:0], ~step[WIDTH]};
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            q     <= q_fix;
            r     <= r_fix;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`ifdef DIVIDER_SD_ZERO_EARLY_EN
            div_zero <= (dvs == '0);
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_sd.sv
// Randomized self-checking bench for divider_sd (WIDTH=32 and WIDTH=8 instances).
// Follows DIVIDER_SD_ZERO_EARLY_EN when the design is built with it.
module tb_divider_sd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        st32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, q32, r32;
  logic        busy32, done32;
  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic        busy8, done8;
`ifdef DIVIDER_SD_ZERO_EARLY_EN
  logic        dz32, dz8;
`endif

  int nvec = 0;
  int nmis = 0;
  logic [31:0] last_q32 = '0;

  always #5 clock = ~clock;

  divider_sd #(.WIDTH(32)) u32 (
    .clock(clock), .reset(reset), .start(st32), .is_signed(sg32),
    .dividend(a32), .divisor(b32), .q(q32), .r(r32), .busy(busy32), .done(done32)
`ifdef DIVIDER_SD_ZERO_EARLY_EN
    , .div_zero(dz32)
`endif
  );

  divider_sd #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(st8), .is_signed(sg8),
    .dividend(a8), .divisor(b8), .q(q8), .r(r8), .busy(busy8), .done(done8)
`ifdef DIVIDER_SD_ZERO_EARLY_EN
    , .div_zero(dz8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void ref_div(input int w, input bit sgn, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned q,
                                  output longint unsigned r);
    longint unsigned mask = (64'd1 << w) - 1;
    longint sa, sb;
    a = a & mask;
    b = b & mask;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = ((a >> (w - 1)) & 1) != 0 ? $signed(a) - $signed(64'd1 << w) : $signed(a);
      sb = ((b >> (w - 1)) & 1) != 0 ? $signed(b) - $signed(64'd1 << w) : $signed(b);
      q = $unsigned(sa / sb) & mask;
      r = $unsigned(sa % sb) & mask;
    end
  endfunction

  function automatic logic cur_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction

  function automatic logic [31:0] cur_q(input int w);
    return (w == 32) ? q32 : {24'd0, q8};
  endfunction

  function automatic logic [31:0] cur_r(input int w);
    return (w == 32) ? r32 : {24'd0, r8};
  endfunction

  // Raise start for one falling edge; returns at the rising edge after the load.
  task automatic drive_start(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    if (w == 32) begin
      st32 = 1'b1; sg32 = sgn; a32 = a; b32 = b;
    end else begin
      st8 = 1'b1; sg8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end
    @(posedge clock);
    st32 = 1'b0;
    st8  = 1'b0;
  endtask

  task automatic wait_done(input int w, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!cur_done(w) && lat < 100) begin
      if (cur_busy(w)) bcnt++;
      @(posedge clock);
      lat++;
    end
  endtask

  task automatic check_result(input int w, input bit sgn, input logic [31:0] a,
                              input logic [31:0] b, input string tag);
    longint unsigned eq, er;
    int lat, bcnt, exp_lat;
    bit zero;
    ref_div(w, sgn, a, b, eq, er);
    zero = (w == 32) ? (b == 0) : (b[7:0] == 0);
    exp_lat = w + 1;
`ifdef DIVIDER_SD_ZERO_EARLY_EN
    if (zero) exp_lat = 1;
`endif
    wait_done(w, lat, bcnt);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bcnt, exp_lat);
    chk({tag, "_q"}, cur_q(w), eq);
    chk({tag, "_r"}, cur_r(w), er);
`ifdef DIVIDER_SD_ZERO_EARLY_EN
    chk({tag, "_dz"}, (w == 32) ? dz32 : dz8, zero);
`endif
    @(posedge clock);
    chk({tag, "_done_clr"}, cur_done(w), 1'b0);
    chk({tag, "_hold"}, cur_q(w), eq);
    if (w == 32) last_q32 = eq[31:0];
  endtask

  task automatic do_div(input int w, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    drive_start(w, sgn, a, b);
    check_result(w, sgn, a, b, tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    #2;
    chk("rst_q", q32, 0);
    chk("rst_r", r32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_q8", q8, 0);
    repeat (2) @(posedge clock);
    reset = 1'b0;

    do_div(32, 0, 32'd100, 32'd7, "u100_7");
    do_div(32, 1, 32'hFFFFFF9C, 32'd7, "sm100_7");
    do_div(32, 1, 32'd100, 32'hFFFFFFF9, "s100_m7");
    do_div(32, 1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");
    do_div(32, 0, 32'hFFFFFFFF, 32'd1, "u_max_1");
    do_div(32, 0, 32'h12345678, 32'd0, "u_dz");
    do_div(32, 1, 32'h12345678, 32'd0, "s_dz");
    do_div(8, 0, 32'd255, 32'd16, "w8_255_16");
    do_div(8, 1, 32'h80, 32'hFF, "w8_ovf");
    do_div(8, 1, 32'h85, 32'h00, "w8_dz");

    // Restart mid-iteration: old q must survive until the new result lands.
    drive_start(32, 0, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    drive_start(32, 0, 32'd50, 32'd5);
    chk("restart_hold_q", q32, last_q32);
    chk("restart_busy", busy32, 1'b1);
    check_result(32, 0, 32'd50, 32'd5, "restart");

    // Asynchronous reset mid-iteration.
    drive_start(32, 0, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy32, 0);
    chk("midrst_q", q32, 0);
    chk("midrst_r", r32, 0);
    @(posedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    chk("midrst_no_done", done32, 0);
    chk("midrst_idle_q", q32, 0);

    for (int i = 0; i < 30; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFFFFFF;
        3: rb = {16'd0, 16'($urandom)};
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      do_div(32, rs, ra, rb, $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 25; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom_range(0, 255);
      do_div(8, rs, ra, rb, $sformatf("rnd8_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
